line_buffer_5row: RTL and testbench

Five-row line buffer feeding the 5x5 defect-pixel-correction stage. It accepts one raster-order 8-bit Bayer pixel stream with its 3-bit video sync. It emits a vertical 5-pixel column: the live row plus the four previous rows at the same horizontal position, with the sync bus delayed to match. Rows not yet filled at the top of the frame are padded. All storage is on-chip line memory inferred as synchronous-read RAM.

---
 rtl/line_buffer_5row.sv | 176 +++++++++++++++++
 tb/tb_line_buffer_5row.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_5row.sv
//------------------------------------------------------------------------------
// Module      : line_buffer_5row
// Description : Five-row line buffer for the 5x5 defect-pixel-correction
//               stage. It emits the live pixel plus the four previous rows at
//               the same column, with the video sync delayed by 2 clk. Rows not
//               yet filled in the current frame are padded.
//               Optional macro LB_EDGE_REPLICATE_EN: an invalid row repeats the
//               nearest valid row below it instead of outputting 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_buffer_5row #(
  parameter int H_MAX  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] i_video_syn,
  input  logic [7:0] i_data,
  output logic [7:0] o_data_r0,
  output logic [7:0] o_data_r1,
  output logic [7:0] o_data_r2,
  output logic [7:0] o_data_r3,
  output logic [7:0] o_data_r4,
  output logic [2:0] o_video_sync,
  output logic       o_lines_primed,
  output logic       o_ovf
);

  // One extra counter bit so the count can reach H_MAX even when
  // H_MAX == 2**ADDR_W, which is needed to detect an over-long line.
  localparam int               CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] H_MAX_C = CNT_W'(H_MAX);

  logic             vs_w, de_w, de_fall_w, vs_fall_w;
  logic             in_range_w, wr_px_w, ovf_px_w;
  logic             de_d_q, vs_d_q;
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [2:0]       line_cnt_q, line_cnt_d;

  // Stage 1 registers
  logic [2:0]        sync_s1_q;
  logic [7:0]        data_s1_q;
  logic [2:0]        lc_s1_q;
  logic              oor_s1_q;
  logic              ovf_s1_q, ovf_s1_d;
  logic              we_s1_q;
  logic [ADDR_W-1:0] addr_s1_q;

  // Line memories M0..M3 packed side by side: [7:0]=M0 ... [31:24]=M3.
  logic [31:0] mem_q [0:H_MAX-1];
  logic [31:0] rd_q;

  logic [7:0] row_w [5];
  logic [7:0] pad_w;

  assign vs_w       = i_video_syn[2];
  assign de_w       = i_video_syn[1];
  assign de_fall_w  = de_d_q & ~de_w;
  assign vs_fall_w  = vs_d_q & ~vs_w;
  assign in_range_w = (col_cnt_q < H_MAX_C);
  assign wr_px_w    = de_w & in_range_w;
  assign ovf_px_w   = de_w & ~in_range_w;

  // Column / line counters and sticky overflow next-state.
  always_comb begin
    col_cnt_d  = col_cnt_q;
    line_cnt_d = line_cnt_q;
    ovf_s1_d   = ovf_s1_q;
    if (de_fall_w)
      col_cnt_d = '0;
    else if (wr_px_w)
      col_cnt_d = col_cnt_q + 1'b1;
    if (vs_fall_w)
      line_cnt_d = '0;
    else if (de_fall_w && (line_cnt_q < 3'd4))
      line_cnt_d = line_cnt_q + 3'd1;
    if (vs_fall_w)
      ovf_s1_d = 1'b0;
    if (ovf_px_w)
      ovf_s1_d = 1'b1;
  end

  // Edge detectors, counters and stage-1 pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_d_q     <= 1'b0;
      vs_d_q     <= 1'b0;
      col_cnt_q  <= '0;
      line_cnt_q <= '0;
      sync_s1_q  <= '0;
      data_s1_q  <= '0;
      lc_s1_q    <= '0;
      oor_s1_q   <= 1'b0;
      ovf_s1_q   <= 1'b0;
      we_s1_q    <= 1'b0;
      addr_s1_q  <= '0;
    end else begin
      de_d_q     <= de_w;
      vs_d_q     <= vs_w;
      col_cnt_q  <= col_cnt_d;
      line_cnt_q <= line_cnt_d;
      sync_s1_q  <= i_video_syn;
      data_s1_q  <= i_data;
      lc_s1_q    <= line_cnt_q;
      oor_s1_q   <= ovf_px_w;
      ovf_s1_q   <= ovf_s1_d;
      we_s1_q    <= wr_px_w;
      addr_s1_q  <= col_cnt_q[ADDR_W-1:0];
    end
  end

  // Synchronous-read line memory. The shifted row word is written one cycle
  // after the read, once the old contents are in rd_q; a later read of the
  // same column is always at least two cycles away, so it sees the update.
  always_ff @(posedge clk) begin
    if (wr_px_w)
      rd_q <= mem_q[col_cnt_q[ADDR_W-1:0]];
    if (we_s1_q)
      mem_q[addr_s1_q] <= {rd_q[23:0], data_s1_q};
  end

  // Value used for a row that is not yet valid in this frame.
  always_comb begin
`ifdef LB_EDGE_REPLICATE_EN
    case (lc_s1_q)
      3'd1:    pad_w = rd_q[7:0];
      3'd2:    pad_w = rd_q[15:8];
      3'd3:    pad_w = rd_q[23:16];
      default: pad_w = data_s1_q;
    endcase
`else
    pad_w = '0;
`endif
  end

  // Row selection: validity from the line count snapshot taken with the pixel.
  always_comb begin
    for (int k = 0; k < 5; k++)
      row_w[k] = '0;
    if (sync_s1_q[1]) begin
      row_w[4] = data_s1_q;
      if (!oor_s1_q) begin
        for (int k = 1; k <= 4; k++)
          row_w[4-k] = (lc_s1_q >= 3'(k)) ? rd_q[8*(k-1) +: 8] : pad_w;
      end
    end
  end

  // Stage-2 output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_data_r0      <= '0;
      o_data_r1      <= '0;
      o_data_r2      <= '0;
      o_data_r3      <= '0;
      o_data_r4      <= '0;
      o_video_sync   <= '0;
      o_lines_primed <= 1'b0;
      o_ovf          <= 1'b0;
    end else begin
      o_data_r0      <= row_w[0];
      o_data_r1      <= row_w[1];
      o_data_r2      <= row_w[2];
      o_data_r3      <= row_w[3];
      o_data_r4      <= row_w[4];
      o_video_sync   <= sync_s1_q;
      o_lines_primed <= (line_cnt_q == 3'd4);
      o_ovf          <= ovf_s1_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_buffer_5row.sv
//------------------------------------------------------------------------------
// Module      : tb_line_buffer_5row
// Description : Scoreboard bench for line_buffer_5row (H_MAX = 8). Each driven
//               cycle pushes the expected output record two cycles ahead; a
//               monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_buffer_5row;

  localparam int H_MAX  = 8;
  localparam int ADDR_W = 3;
`ifdef LB_EDGE_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] i_video_syn = '0;
  logic [7:0] i_data = '0;
  logic [7:0] o_data_r0, o_data_r1, o_data_r2, o_data_r3, o_data_r4;
  logic [2:0] o_video_sync;
  logic       o_lines_primed, o_ovf;

  always #5 clk = ~clk;

  line_buffer_5row #(.H_MAX(H_MAX), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_video_syn    (i_video_syn),
    .i_data         (i_data),
    .o_data_r0      (o_data_r0),
    .o_data_r1      (o_data_r1),
    .o_data_r2      (o_data_r2),
    .o_data_r3      (o_data_r3),
    .o_data_r4      (o_data_r4),
    .o_video_sync   (o_video_sync),
    .o_lines_primed (o_lines_primed),
    .o_ovf          (o_ovf)
  );

  typedef struct packed {
    logic        rst;
    logic [2:0]  sync;
    logic [39:0] rows;   // {r0, r1, r2, r3, r4}
    logic        ovf;
    logic        primed;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: per-column history of written pixels (newest first).
  logic [7:0] hist [H_MAX][$];
  int         m_col = 0;
  int         m_lc  = 0;
  bit         m_ovf = 0;
  bit         m_de_d = 0;
  bit         m_vs_d = 0;

  task automatic drive(input bit rst, input bit vs, input bit de, input bit hs,
                       input logic [7:0] d);
    exp_t       e;
    logic [7:0] r [5];
    bit         def, vsf;
    @(posedge clk);
    #1;
    reset_n     = ~rst;
    i_video_syn = {vs, de, hs};
    i_data      = d;
    e           = '0;
    e.rst       = rst;
    if (rst) begin
      m_col = 0; m_lc = 0; m_ovf = 0; m_de_d = 0; m_vs_d = 0;
    end else begin
      e.sync = {vs, de, hs};
      for (int k = 0; k < 5; k++) r[k] = 8'h00;
      def = m_de_d && !de;
      vsf = m_vs_d && !vs;
      if (vsf) m_ovf = 0;
      if (de) begin
        r[4] = d;
        if (m_col < H_MAX) begin
          for (int k = 1; k <= 4; k++) begin
            if (m_lc >= k)
              r[4-k] = (hist[m_col].size() >= k) ? hist[m_col][k-1] : 8'h00;
            else if (REPL)
              r[4-k] = r[4-m_lc];
          end
          hist[m_col].push_front(d);
          if (hist[m_col].size() > 4) void'(hist[m_col].pop_back());
          m_col++;
        end else begin
          m_ovf = 1;
        end
      end
      if (def) m_col = 0;
      if (vsf) m_lc = 0;
      else if (def && m_lc < 4) m_lc++;
      e.rows   = {r[0], r[1], r[2], r[3], r[4]};
      e.ovf    = m_ovf;
      e.primed = (m_lc == 4);
      m_de_d   = de;
      m_vs_d   = vs;
    end
    sbq.push_back(e);
  endtask

  // One frame: optional vsync pulse, h lines of w pixels, random gaps.
  // vs_end holds vsync high on the last pixel so vs_fall meets de_fall.
  // rst_after injects a reset in the gap after that line index (-1 = none).
  task automatic frame(input int w, input int h, input bit pat, input int gap_max,
                       input bit pulse, input bit vs_end, input int rst_after);
    int         gap;
    logic [7:0] d;
    if (pulse) begin
      repeat (3) drive(0, 1, 0, 0, 8'($urandom));
      drive(0, 0, 0, 0, 8'($urandom));
    end
    for (int row = 0; row < h; row++) begin
      for (int col = 0; col < w; col++) begin
        d = pat ? 8'(16 * row + col) : 8'($urandom);
        drive(0, vs_end && (row == h - 1) && (col == w - 1), 1, 0, d);
      end
      gap = $urandom_range(gap_max, 1);
      for (int g = 0; g < gap; g++)
        drive(0, 0, 0, (g == 0) ? 1'b1 : 1'($urandom), 8'($urandom));
      if (row == rst_after) begin
        repeat (3) drive(1, 0, 1, 0, 8'hFF);
      end
    end
  endtask

  exp_t mon_e;
  bit   mon_z;

  // Monitor: one record per cycle, output due two cycles after its input.
  always @(negedge clk) begin
    if (sbq.size() >= 3) begin
      mon_e = sbq.pop_front();
      mon_z = mon_e.rst | sbq[0].rst | sbq[1].rst;
      if (mon_z) mon_e = '0;
      n_checks++;
      if (o_video_sync !== mon_e.sync) begin
        n_fail++;
        $display("FAIL sync @%0t: got %b expected %b", $time, o_video_sync, mon_e.sync);
      end
      n_checks++;
      if ({o_data_r0, o_data_r1, o_data_r2, o_data_r3, o_data_r4} !== mon_e.rows) begin
        n_fail++;
        $display("FAIL rows @%0t: got r0..r4=%h expected %h", $time,
                 {o_data_r0, o_data_r1, o_data_r2, o_data_r3, o_data_r4}, mon_e.rows);
      end
      n_checks++;
      if (o_ovf !== mon_e.ovf) begin
        n_fail++;
        $display("FAIL ovf @%0t: got %b expected %b", $time, o_ovf, mon_e.ovf);
      end
      n_checks++;
      if (o_lines_primed !== mon_e.primed) begin
        n_fail++;
        $display("FAIL primed @%0t: got %b expected %b", $time, o_lines_primed, mon_e.primed);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held while de=1 and data=0xFF.
    repeat (5) drive(1, 0, 1, 0, 8'hFF);
    repeat (3) drive(0, 0, 0, 0, 8'h00);
    // 8x8 patterned frame (pixel = 16*row + col).
    frame(8, 8, 1, 3, 1, 0, -1);
    // New frame after 6 lines, vs_fall coincident with de_fall.
    frame(8, 6, 0, 1, 1, 1, -1);
    frame(8, 5, 0, 1, 0, 0, -1);
    // Over-long lines, then a normal frame clears the sticky flag.
    frame(10, 5, 0, 2, 1, 0, -1);
    frame(8, 6, 1, 1, 1, 0, -1);
    // Mid-frame reset in a blanking gap.
    frame(6, 8, 0, 2, 1, 0, 2);
    // Random frames with random widths and blanking.
    for (int f = 0; f < 12; f++)
      frame($urandom_range(10, 1), $urandom_range(7, 1), 0, $urandom_range(4, 1), 1,
            1'($urandom_range(1, 0)), -1);
    repeat (4) drive(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
